// File: rtl/jt12_pkg.sv
// Shared widths for the YM2612 timer A/B block.
package jt12_pkg;
  localparam int TA_W               = 10;
  localparam int TB_W               = 8;
  localparam int TB_PRESC_W_DEFAULT = 4;
endpackage

// File: rtl/jt12_timer_cnt.sv
// Reloadable up-counter with a load-edge reload, an overflow pulse and a status flag.
module jt12_timer_cnt
  import jt12_pkg::*;
#(
  parameter int W = TA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clk_en_i,
  input  logic         load_i,
  input  logic         advance_i,
  input  logic [W-1:0] start_value_i,
  input  logic         en_irq_i,
  input  logic         clr_flag_i,
  output logic         load_q_o,
  output logic         overflow_o,
  output logic         flag_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         load_q;
  logic         ovf_q;
  logic         flag_q, flag_d;
  logic         load_edge;
  logic         wrap;

  // A rising load edge reloads without advancing; wrap reloads the preset, not zero.
  always_comb begin
    load_edge = load_i & ~load_q;
    wrap      = load_i & load_q & advance_i & (cnt_q == {W{1'b1}});
    cnt_d     = cnt_q;
    if (load_edge) begin
      cnt_d = start_value_i;
    end else if (load_i & advance_i) begin
      cnt_d = wrap ? start_value_i : cnt_q + 1'b1;
    end
    flag_d = (wrap & en_irq_i) | (flag_q & ~clr_flag_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      load_q <= 1'b0;
      ovf_q  <= 1'b0;
      flag_q <= 1'b0;
    end else if (clk_en_i) begin
      cnt_q  <= cnt_d;
      load_q <= load_i;
      ovf_q  <= wrap;
      flag_q <= flag_d;
    end
  end

  assign load_q_o   = load_q;
  assign overflow_o = ovf_q;
  assign flag_o     = flag_q;

endmodule

// File: rtl/jt12_timer_ab.sv
// YM2612 timers A and B: A counts FM sample ticks, B counts ticks through a prescaler.
module jt12_timer_ab
  import jt12_pkg::*;
#(
  parameter int TB_PRESC_W = TB_PRESC_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clk_en,
  input  logic            tick,
  input  logic [TA_W-1:0] value_A,
  input  logic [TB_W-1:0] value_B,
  input  logic            load_A,
  input  logic            load_B,
  input  logic            en_irq_A,
  input  logic            en_irq_B,
  input  logic            clr_flag_A,
  input  logic            clr_flag_B,
  output logic            overflow_A,
  output logic            flag_A,
  output logic            flag_B,
  output logic            irq_n
);

  logic [TB_PRESC_W-1:0] presc_q, presc_d;
  logic                  b_load_q;
  logic                  b_advance;
  logic                  irq_n_q;
  logic                  a_load_q_unused;
  logic                  overflow_b_unused;

  // The prescaler restarts on B's load edge so the first B period is always full.
  always_comb begin
    presc_d = presc_q;
    if (load_B & ~b_load_q) begin
      presc_d = '0;
    end else if (load_B & tick) begin
      presc_d = presc_q + 1'b1;
    end
    b_advance = tick & (presc_q == {TB_PRESC_W{1'b1}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      irq_n_q <= 1'b1;
    end else if (clk_en) begin
      presc_q <= presc_d;
      irq_n_q <= ~(flag_A | flag_B);
    end
  end

  jt12_timer_cnt #(.W(TA_W)) u_timer_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .clk_en_i     (clk_en),
    .load_i       (load_A),
    .advance_i    (tick),
    .start_value_i(value_A),
    .en_irq_i     (en_irq_A),
    .clr_flag_i   (clr_flag_A),
    .load_q_o     (a_load_q_unused),
    .overflow_o   (overflow_A),
    .flag_o       (flag_A)
  );

  jt12_timer_cnt #(.W(TB_W)) u_timer_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .clk_en_i     (clk_en),
    .load_i       (load_B),
    .advance_i    (b_advance),
    .start_value_i(value_B),
    .en_irq_i     (en_irq_B),
    .clr_flag_i   (clr_flag_B),
    .load_q_o     (b_load_q),
    .overflow_o   (overflow_b_unused),
    .flag_o       (flag_B)
  );

  assign irq_n = irq_n_q;

endmodule

// File: tb/tb_jt12_timer_ab.sv
// Randomised and directed bench for jt12_timer_ab against a ticks-remaining model.
module tb_jt12_timer_ab;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_en = 1'b0;
  logic       tick = 1'b0;
  logic [9:0] value_A = '0;
  logic [7:0] value_B = '0;
  logic       load_A = 1'b0, load_B = 1'b0;
  logic       en_irq_A = 1'b0, en_irq_B = 1'b0;
  logic       clr_flag_A = 1'b0, clr_flag_B = 1'b0;
  logic       overflow_A, flag_A, flag_B, irq_n;

  jt12_timer_ab dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_en    (clk_en),
    .tick      (tick),
    .value_A   (value_A),
    .value_B   (value_B),
    .load_A    (load_A),
    .load_B    (load_B),
    .en_irq_A  (en_irq_A),
    .en_irq_B  (en_irq_B),
    .clr_flag_A(clr_flag_A),
    .clr_flag_B(clr_flag_B),
    .overflow_A(overflow_A),
    .flag_A    (flag_A),
    .flag_B    (flag_B),
    .irq_n     (irq_n)
  );

  // clock / reset
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // expected {overflow_A, flag_A, flag_B, irq_n} after each clock edge
  logic [3:0] exp_q[$];
  logic [3:0] mon_e;

  // reference model: ticks remaining until each timer's next overflow
  int a_left, b_left;
  bit la_prev, lb_prev;
  bit m_ovf, m_fa, m_fb, m_irqn;

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got={ovfA,flagA,flagB,irq_n}=%b expected=%b at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    a_left  = 1024;
    b_left  = 4096;
    la_prev = 1'b0;
    lb_prev = 1'b0;
    m_ovf   = 1'b0;
    m_fa    = 1'b0;
    m_fb    = 1'b0;
    m_irqn  = 1'b1;
  endfunction

  function automatic void model_step();
    bit ova, ovb, nirq;
    ova = 1'b0;
    ovb = 1'b0;
    if (clk_en) begin
      nirq = !(m_fa || m_fb);
      if (load_A && !la_prev) a_left = 1024 - int'(value_A);
      else if (load_A && tick) begin
        a_left--;
        if (a_left == 0) begin
          ova    = 1'b1;
          a_left = 1024 - int'(value_A);
        end
      end
      if (load_B && !lb_prev) b_left = 16 * (256 - int'(value_B));
      else if (load_B && tick) begin
        b_left--;
        if (b_left == 0) begin
          ovb    = 1'b1;
          b_left = 16 * (256 - int'(value_B));
        end
      end
      la_prev = load_A;
      lb_prev = load_B;
      if (ova && en_irq_A) m_fa = 1'b1;
      else if (clr_flag_A) m_fa = 1'b0;
      if (ovb && en_irq_B) m_fb = 1'b1;
      else if (clr_flag_B) m_fb = 1'b0;
      m_ovf  = ova;
      m_irqn = nirq;
    end
    exp_q.push_back({m_ovf, m_fa, m_fb, m_irqn});
  endfunction

  // driver: inputs change at the falling edge, expectation pushed for the next rising edge
  task automatic cyc(input bit ce, input bit tk);
    clk_en = ce;
    tick   = ce & tk;
    model_step();
    @(negedge clk);
  endtask

  task automatic run_ticks(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b1);
      for (int j = 1; j < gap; j++) cyc(($urandom_range(0, 7) != 0), 1'b0);
    end
  endtask

  task automatic strobe_clr(input bit a, input bit b);
    clr_flag_A = a;
    clr_flag_B = b;
    cyc(1'b1, 1'b0);
    clr_flag_A = 1'b0;
    clr_flag_B = 1'b0;
  endtask

  task automatic reset_pulse();
    rst_n  = 1'b0;
    clk_en = 1'b0;
    tick   = 1'b0;
    #1;
    check("async_reset", {overflow_A, flag_A, flag_B, irq_n}, 4'b0001);
    model_reset();
    cyc(1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  // monitor: compares away from the active edge
  always @(posedge clk) begin
    #2;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check("outputs", {overflow_A, flag_A, flag_B, irq_n}, mon_e);
    end
  end

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("reset_state", {overflow_A, flag_A, flag_B, irq_n}, 4'b0001);
    rst_n = 1'b1;
    cyc(1'b1, 1'b1);

    // timer A period 4, tick every 24 clk_en cycles
    value_A  = 10'd1020;
    en_irq_A = 1'b1;
    load_A   = 1'b1;
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b1);
      for (int j = 1; j < 24; j++) cyc(1'b1, 1'b0);
    end
    strobe_clr(1'b1, 1'b0);

    // overflow coincident with clear: set wins
    load_A  = 1'b0;
    cyc(1'b1, 1'b0);
    value_A = 10'd1022;
    load_A  = 1'b1;
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    clr_flag_A = 1'b1;
    cyc(1'b1, 1'b1);
    clr_flag_A = 1'b0;
    cyc(1'b1, 1'b0);
    strobe_clr(1'b1, 1'b0);

    // timer B: 32 ticks to overflow with value 254
    value_B  = 8'd254;
    en_irq_B = 1'b1;
    load_B   = 1'b1;
    cyc(1'b1, 1'b0);
    run_ticks(34, 2);
    en_irq_B = 1'b0;
    cyc(1'b1, 1'b0);
    strobe_clr(1'b0, 1'b1);
    load_B = 1'b0;

    // hold while load_A is low, restart from a new preset
    load_A  = 1'b0;
    value_A = 10'd990;
    cyc(1'b1, 1'b0);
    load_A = 1'b1;
    cyc(1'b1, 1'b0);
    run_ticks(10, 1);
    load_A = 1'b0;
    run_ticks(50, 2);
    value_A = 10'd900;
    load_A  = 1'b1;
    cyc(1'b1, 1'b0);
    run_ticks(130, 1);
    strobe_clr(1'b1, 1'b0);

    // reset mid-count with load_A held high
    load_A  = 1'b0;
    value_A = 10'd1010;
    cyc(1'b1, 1'b0);
    load_A = 1'b1;
    run_ticks(12, 2);
    reset_pulse();
    run_ticks(16, 2);

    // every-tick overflow with interrupts disabled
    en_irq_A = 1'b0;
    load_A   = 1'b0;
    strobe_clr(1'b1, 1'b1);
    value_A = 10'd1023;
    load_A  = 1'b1;
    cyc(1'b1, 1'b0);
    run_ticks(10, 1);
    run_ticks(6, 3);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) load_A = ~load_A;
      if ($urandom_range(0, 199) == 0) load_B = ~load_B;
      if ($urandom_range(0, 99) == 0) value_A = 10'($urandom_range(1000, 1023));
      if ($urandom_range(0, 99) == 0) value_B = 8'($urandom_range(250, 255));
      if ($urandom_range(0, 99) == 0) en_irq_A = ~en_irq_A;
      if ($urandom_range(0, 99) == 0) en_irq_B = ~en_irq_B;
      clr_flag_A = ($urandom_range(0, 49) == 0);
      clr_flag_B = ($urandom_range(0, 49) == 0);
      cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
    end
    clr_flag_A = 1'b0;
    clr_flag_B = 1'b0;
    cyc(1'b0, 1'b0);

    // drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
